sorted_frame_serializer: RTL and testbench

- Downstream stage of the 16-to-32 odd-even merger: captures the merged, ascending-sorted vector of 2*n elements and streams it out one element per cycle over a valid/ready interface.
- Frees the merger to accept the next frame as soon as capture completes.
- Provides frame-level status (busy, done) and per-element index and last flags to the V2V consumer.

---
 rtl/sorted_frame_serializer.sv | 104 ++++++++++
 tb/tb_sorted_frame_serializer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sorted_frame_serializer.sv
// sorted_frame_serializer: captures a 2*n-element ascending-sorted frame from
// the merger and streams it out one element per cycle over valid/ready.
// Optional build macro: SERIALIZER_SKIP_ZERO_EN -- skip leading zero (empty)
// elements; an all-zero frame goes straight to DONE.
module sorted_frame_serializer #(
  parameter int WIDTH = 3,
  parameter int n     = 16,
  parameter int IDXW  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cap,
  input  logic [2*n*WIDTH-1:0]   inc,
  output logic                   busy,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDXW-1:0]        out_idx,
  output logic                   out_last,
  output logic                   done
);

  localparam int              NEL      = 2 * n;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NEL - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [IDXW-1:0]              idx_q, idx_d;
  logic [NEL-1:0][WIDTH-1:0]    buf_q, buf_d;
  logic [NEL-1:0][WIDTH-1:0]    inc_v;
  logic [IDXW-1:0]              start_idx;
  logic                         all_zero;

  assign inc_v = inc;

`ifdef SERIALIZER_SKIP_ZERO_EN
  // Count leading zero (empty-slot) elements of the incoming frame
  always_comb begin
    start_idx = '0;
    all_zero  = 1'b1;
    for (int k = 0; k < NEL; k++) begin
      if (all_zero && (inc_v[k] != '0)) begin
        start_idx = IDXW'(k);
        all_zero  = 1'b0;
      end
    end
  end
`else
  assign start_idx = '0;
  assign all_zero  = 1'b0;
`endif

  // State, index and frame buffer registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state logic: capture in IDLE, advance on transfers, one-cycle DONE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    unique case (state_q)
      S_IDLE: begin
        if (cap) begin
          buf_d   = inc_v;
          idx_d   = start_idx;
          state_d = all_zero ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) state_d = S_DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state, never on out_ready
  always_comb begin
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_STREAM);
    done      = (state_q == S_DONE);
    out_last  = (state_q == S_STREAM) && (idx_q == LAST_IDX);
    out_idx   = idx_q;
    out_data  = '0;
    for (int k = 0; k < NEL; k++) begin
      if (idx_q == IDXW'(k)) out_data = buf_q[k];
    end
  end

endmodule

// File: tb/tb_sorted_frame_serializer.sv
// Directed bench for sorted_frame_serializer (n=16, WIDTH=3).
module tb_sorted_frame_serializer;

  localparam int WIDTH = 3;
  localparam int N     = 16;
  localparam int NEL   = 2 * N;
  localparam int IDXW  = 6;
  localparam int FW    = NEL * WIDTH;

  logic            clk = 1'b0;
  logic            rst;
  logic            cap;
  logic [FW-1:0]   inc;
  logic            busy;
  logic [WIDTH-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic [IDXW-1:0] out_idx;
  logic            out_last;
  logic            done;

  int errors = 0;
  int checks = 0;

  logic [FW-1:0] frame_a;
  logic [FW-1:0] frame_b;

  sorted_frame_serializer #(.WIDTH(WIDTH), .n(N), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .cap(cap), .inc(inc), .busy(busy),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected first index for a frame under the current build
  function automatic int first_idx(input logic [FW-1:0] f);
    int r;
    r = 0;
`ifdef SERIALIZER_SKIP_ZERO_EN
    r = NEL;
    for (int k = NEL - 1; k >= 0; k--)
      if (f[k*WIDTH +: WIDTH] != '0) r = k;
`endif
    return r;
  endfunction

  // Capture frame f and follow it to completion; optional stall, second cap,
  // or mid-stream reset at the given element index (-1 = none)
  task automatic run_frame(input logic [FW-1:0] f, input int stall_at,
                           input int cap2_at, input int rst_at);
    int first;
    first = first_idx(f);
    @(negedge clk);
    cap = 1'b1; inc = f; out_ready = 1'b1;
    @(negedge clk);
    cap = 1'b0;
    for (int k = first; k < NEL; k++) begin
      chk("valid", 32'(out_valid), 32'd1);
      chk("idx",   32'(out_idx), 32'(k));
      chk("data",  32'(out_data), 32'(f[k*WIDTH +: WIDTH]));
      chk("last",  32'(out_last), 32'(k == NEL - 1));
      chk("busy",  32'(busy), 32'd1);
      chk("done_in_stream", 32'(done), 32'd0);
      if (k == rst_at) begin
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_idx",   32'(out_idx), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_done",  32'(done), 32'd0);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        return;
      end
      cap = (k == cap2_at);
      if (k == cap2_at) inc = frame_b;
      if (k == stall_at) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_idx",   32'(out_idx), 32'(k));
          chk("stall_data",  32'(out_data), 32'(f[k*WIDTH +: WIDTH]));
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      cap = 1'b0;
    end
    chk("done",      32'(done), 32'd1);
    chk("done_valid", 32'(out_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_last", 32'(out_last), 32'd0);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("single_done", 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b0; cap = 1'b0; inc = '0; out_ready = 1'b0;
    for (int k = 0; k < NEL; k++) begin
      frame_a[k*WIDTH +: WIDTH] = WIDTH'(k >> 2);
      frame_b[k*WIDTH +: WIDTH] = 3'd7;
    end

    // Reset held two cycles, then released
    repeat (2) @(negedge clk);
    chk("reset_busy",  32'(busy), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_done",  32'(done), 32'd0);
    chk("reset_idx",   32'(out_idx), 32'd0);
    chk("reset_data",  32'(out_data), 32'd0);
    chk("reset_last",  32'(out_last), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_rst_busy",  32'(busy), 32'd0);
    chk("idle_after_rst_valid", 32'(out_valid), 32'd0);

    // Full stream, no backpressure
    run_frame(frame_a, -1, -1, -1);
    // Backpressure at idx 5
    run_frame(frame_a, 5, -1, -1);
    // Second capture while busy is ignored
    run_frame(frame_a, -1, 10, -1);
    // Reset mid-stream, then a fresh frame streams from the start
    run_frame(frame_a, -1, -1, 20);
    run_frame(frame_a, -1, -1, -1);

`ifdef SERIALIZER_SKIP_ZERO_EN
    begin
      logic [FW-1:0] f6;
      for (int k = 0; k < NEL; k++)
        f6[k*WIDTH +: WIDTH] = (k < 12) ? 3'd0 : 3'd5;
      run_frame(f6, -1, -1, -1);
      @(negedge clk);
      cap = 1'b1; inc = '0;
      @(negedge clk);
      cap = 1'b0;
      chk("zero_valid", 32'(out_valid), 32'd0);
      chk("zero_done",  32'(done), 32'd1);
      chk("zero_busy",  32'(busy), 32'd1);
      @(negedge clk);
      chk("zero_idle_busy", 32'(busy), 32'd0);
      chk("zero_idle_done", 32'(done), 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
